serial_fifo_iface: RTL and testbench

//  Parametrised UART command-byte interface for the OpenADC register layer.

---
 rtl/serial_fifo_iface_pkg.sv | 30 +++
 rtl/serial_byte_fifo.sv | 55 +++++
 rtl/serial_fifo_iface.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_serial_fifo_iface.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_fifo_iface_pkg.sv
// Shared definitions for the UART command-byte interface: engine state encodings,
// error-bit indices and the divisor floor. Parity is enabled by SERIAL_FIFO_IFACE_PARITY_EN.
package serial_fifo_iface_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned ERR_OVR = 0;
  localparam int unsigned ERR_FRM = 1;
  localparam int unsigned ERR_PAR = 2;

  localparam int unsigned MIN_DIV = 7;

`ifdef SERIAL_FIFO_IFACE_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/serial_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO with occupancy output.
// Reads while empty are ignored; a write while full succeeds only alongside a read.
module serial_byte_fifo #(
  parameter int unsigned AW = 4
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        empty,
  output logic        full,
  output logic [AW:0] level
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          rd_ok;
  logic          wr_ok;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);
  assign level = cnt;

  // Head is forced to zero while empty so the output is defined out of reset.
  assign rd_data = empty ? '0 : mem[rptr];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/serial_fifo_iface.sv
// UART RX/TX engines with byte FIFOs presenting the cmdfifo_* handshake to the register decoder.
// Optional even parity is enabled by defining SERIAL_FIFO_IFACE_PARITY_EN.
module serial_fifo_iface
  import serial_fifo_iface_pkg::*;
#(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned RX_AW = 4,
  parameter int unsigned TX_AW = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             rx_i,
  output logic             tx_o,
  input  logic [DIV_W-1:0] baud_div_i,
  output logic             cmdfifo_rxf,
  input  logic             cmdfifo_rd,
  output logic [7:0]       cmdfifo_din,
  output logic             cmdfifo_txe,
  input  logic             cmdfifo_wr,
  input  logic [7:0]       cmdfifo_dout,
  output logic [RX_AW:0]   rx_level_o,
  output logic [TX_AW:0]   tx_level_o,
  output logic [2:0]       err_o,
  input  logic             err_clr_i
);

  logic [DIV_W-1:0] div_eff;
  assign div_eff = (baud_div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div_i;

  // ---------------- RX engine ----------------
  logic [1:0]       rx_sync;
  logic             rx_s;
  logic             rx_d;
  uart_state_e      rx_state,    rx_state_nx;
  logic [DIV_W-1:0] rx_cnt,      rx_cnt_nx;
  logic [DIV_W-1:0] rx_div,      rx_div_nx;
  logic [2:0]       rx_bit,      rx_bit_nx;
  logic [7:0]       rx_sh,       rx_sh_nx;
  logic             rx_par,      rx_par_nx;
  logic             rx_brk,      rx_brk_nx;
  logic             rx_push,     rx_push_nx;
  logic             set_frm;
  logic             set_par;
  logic             rx_empty;
  logic             rx_full;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_sync  <= 2'b11;
      rx_d     <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_par   <= 1'b0;
      rx_brk   <= 1'b0;
      rx_push  <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], rx_i};
      rx_d     <= rx_s;
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_div   <= rx_div_nx;
      rx_bit   <= rx_bit_nx;
      rx_sh    <= rx_sh_nx;
      rx_par   <= rx_par_nx;
      rx_brk   <= rx_brk_nx;
      rx_push  <= rx_push_nx;
    end
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_div_nx   = rx_div;
    rx_bit_nx   = rx_bit;
    rx_sh_nx    = rx_sh;
    rx_par_nx   = rx_par;
    rx_brk_nx   = rx_brk;
    rx_push_nx  = 1'b0;
    set_frm     = 1'b0;
    set_par     = 1'b0;
    case (rx_state)
      S_IDLE: begin
        if (rx_d && !rx_s) begin
          rx_div_nx   = div_eff;
          rx_cnt_nx   = div_eff >> 1;
          rx_state_nx = S_START;
        end
      end
      S_START: begin
        if (rx_cnt == '0) begin
          if (!rx_s) begin
            rx_cnt_nx   = rx_div;
            rx_bit_nx   = '0;
            rx_state_nx = S_DATA;
          end else begin
            rx_state_nx = S_IDLE;
          end
        end else begin
          rx_cnt_nx = rx_cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (rx_cnt == '0) begin
          rx_sh_nx  = {rx_s, rx_sh[7:1]};
          rx_cnt_nx = rx_div;
          rx_bit_nx = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_nx = PARITY_EN ? S_PARITY : S_STOP;
        end else begin
          rx_cnt_nx = rx_cnt - 1'b1;
        end
      end
      S_PARITY: begin
        if (rx_cnt == '0) begin
          rx_par_nx   = rx_s;
          rx_cnt_nx   = rx_div;
          rx_state_nx = S_STOP;
        end else begin
          rx_cnt_nx = rx_cnt - 1'b1;
        end
      end
      S_STOP: begin
        // After a framing error the engine parks here until the line returns high.
        if (rx_brk) begin
          if (rx_s) begin
            rx_brk_nx   = 1'b0;
            rx_state_nx = S_IDLE;
          end
        end else if (rx_cnt == '0) begin
          if (!rx_s) begin
            set_frm   = 1'b1;
            rx_brk_nx = 1'b1;
          end else if (PARITY_EN && (rx_par != even_parity(rx_sh))) begin
            set_par     = 1'b1;
            rx_state_nx = S_IDLE;
          end else begin
            rx_push_nx  = 1'b1;
            rx_state_nx = S_IDLE;
          end
        end else begin
          rx_cnt_nx = rx_cnt - 1'b1;
        end
      end
      default: rx_state_nx = S_IDLE;
    endcase
  end

  serial_byte_fifo #(.AW(RX_AW)) u_rx_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .wr_en     (rx_push),
    .wr_data   (rx_sh),
    .rd_en     (cmdfifo_rd),
    .rd_data   (cmdfifo_din),
    .empty     (rx_empty),
    .full      (rx_full),
    .level     (rx_level_o)
  );

  assign cmdfifo_rxf = ~rx_empty;

  // ---------------- error flags ----------------
  logic [2:0] err_q;
  logic [2:0] err_set;

  always_comb begin
    err_set          = '0;
    err_set[ERR_OVR] = rx_push & rx_full & ~cmdfifo_rd;
    err_set[ERR_FRM] = set_frm;
    err_set[ERR_PAR] = PARITY_EN & set_par;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) err_q <= '0;
    else            err_q <= (err_clr_i ? 3'b000 : err_q) | err_set;
  end

  assign err_o = err_q;

  // ---------------- TX engine ----------------
  uart_state_e      tx_state, tx_state_nx;
  logic [DIV_W-1:0] tx_cnt,   tx_cnt_nx;
  logic [DIV_W-1:0] tx_div,   tx_div_nx;
  logic [2:0]       tx_bit,   tx_bit_nx;
  logic [7:0]       tx_sh,    tx_sh_nx;
  logic             tx_par,   tx_par_nx;
  logic             tx_q,     tx_q_nx;
  logic             tx_load;
  logic [7:0]       tx_head;
  logic             tx_empty;
  logic             tx_full;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_div   <= tx_div_nx;
      tx_bit   <= tx_bit_nx;
      tx_sh    <= tx_sh_nx;
      tx_par   <= tx_par_nx;
      tx_q     <= tx_q_nx;
    end
  end

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_div_nx   = tx_div;
    tx_bit_nx   = tx_bit;
    tx_sh_nx    = tx_sh;
    tx_par_nx   = tx_par;
    tx_q_nx     = tx_q;
    tx_load     = 1'b0;
    case (tx_state)
      S_IDLE: begin
        if (!tx_empty) tx_load = 1'b1;
      end
      S_START: begin
        if (tx_cnt == '0) begin
          tx_cnt_nx   = tx_div;
          tx_q_nx     = tx_sh[0];
          tx_state_nx = S_DATA;
        end else begin
          tx_cnt_nx = tx_cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_nx = tx_div;
          if (tx_bit == 3'd7) begin
            if (PARITY_EN) begin
              tx_q_nx     = tx_par;
              tx_state_nx = S_PARITY;
            end else begin
              tx_q_nx     = 1'b1;
              tx_state_nx = S_STOP;
            end
          end else begin
            tx_bit_nx = tx_bit + 3'd1;
            tx_sh_nx  = tx_sh >> 1;
            tx_q_nx   = tx_sh[1];
          end
        end else begin
          tx_cnt_nx = tx_cnt - 1'b1;
        end
      end
      S_PARITY: begin
        if (tx_cnt == '0) begin
          tx_cnt_nx   = tx_div;
          tx_q_nx     = 1'b1;
          tx_state_nx = S_STOP;
        end else begin
          tx_cnt_nx = tx_cnt - 1'b1;
        end
      end
      S_STOP: begin
        // Chain straight into the next start bit so queued frames have no idle gap.
        if (tx_cnt == '0) begin
          if (!tx_empty) begin
            tx_load = 1'b1;
          end else begin
            tx_q_nx     = 1'b1;
            tx_state_nx = S_IDLE;
          end
        end else begin
          tx_cnt_nx = tx_cnt - 1'b1;
        end
      end
      default: tx_state_nx = S_IDLE;
    endcase

    if (tx_load) begin
      tx_sh_nx    = tx_head;
      tx_par_nx   = even_parity(tx_head);
      tx_div_nx   = div_eff;
      tx_cnt_nx   = div_eff;
      tx_bit_nx   = '0;
      tx_q_nx     = 1'b0;
      tx_state_nx = S_START;
    end
  end

  serial_byte_fifo #(.AW(TX_AW)) u_tx_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .wr_en     (cmdfifo_wr),
    .wr_data   (cmdfifo_dout),
    .rd_en     (tx_load),
    .rd_data   (tx_head),
    .empty     (tx_empty),
    .full      (tx_full),
    .level     (tx_level_o)
  );

  assign cmdfifo_txe = ~tx_full;
  assign tx_o        = tx_q;

endmodule

// File: tb/tb_serial_fifo_iface.sv
// Directed self-checking bench for serial_fifo_iface: table-driven RX frames plus
// hand-written TX, overflow, divisor-floor, parity and reset sequences.
module tb_serial_fifo_iface;

`ifdef SERIAL_FIFO_IFACE_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int BIT = 10;
  localparam int FB  = PAR ? 11 : 10;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        rx_i;
  logic        tx_o;
  logic [15:0] baud_div_i;
  logic        cmdfifo_rxf;
  logic        cmdfifo_rd;
  logic [7:0]  cmdfifo_din;
  logic        cmdfifo_txe;
  logic        cmdfifo_wr;
  logic [7:0]  cmdfifo_dout;
  logic [4:0]  rx_level_o;
  logic [4:0]  tx_level_o;
  logic [2:0]  err_o;
  logic        err_clr_i;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  serial_fifo_iface #(.DIV_W(16), .RX_AW(4), .TX_AW(4)) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .rx_i         (rx_i),
    .tx_o         (tx_o),
    .baud_div_i   (baud_div_i),
    .cmdfifo_rxf  (cmdfifo_rxf),
    .cmdfifo_rd   (cmdfifo_rd),
    .cmdfifo_din  (cmdfifo_din),
    .cmdfifo_txe  (cmdfifo_txe),
    .cmdfifo_wr   (cmdfifo_wr),
    .cmdfifo_dout (cmdfifo_dout),
    .rx_level_o   (rx_level_o),
    .tx_level_o   (tx_level_o),
    .err_o        (err_o),
    .err_clr_i    (err_clr_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop, input logic par_flip);
    @(negedge clk_i) rx_i = 1'b0;
    repeat (BIT) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      repeat (BIT) @(negedge clk_i);
    end
    if (PAR) begin
      rx_i = (^d) ^ par_flip;
      repeat (BIT) @(negedge clk_i);
    end
    rx_i = stop;
    repeat (BIT) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (2 * BIT) @(negedge clk_i);
  endtask

  task automatic pop();
    @(negedge clk_i) cmdfifo_rd = 1'b1;
    @(negedge clk_i) cmdfifo_rd = 1'b0;
  endtask

  task automatic clear_err();
    @(negedge clk_i) err_clr_i = 1'b1;
    @(negedge clk_i) err_clr_i = 1'b0;
  endtask

  // Waits for a start bit, then samples each bit at its midpoint.
  task automatic tx_capture(input int period, input int max_wait,
                            output logic [7:0] b, output logic p, output int t,
                            output logic [4:0] lvl, output logic txe_s, output bit ok);
    ok = 1'b0; b = '0; p = 1'b0; t = 0; lvl = '0; txe_s = 1'b0;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk_i);
      if (tx_o == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      t = cyc;
      repeat (period / 2) @(negedge clk_i);
      lvl   = tx_level_o;
      txe_s = cmdfifo_txe;
      if (tx_o !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (period) @(negedge clk_i);
        b[i] = tx_o;
      end
      if (PAR) begin
        repeat (period) @(negedge clk_i);
        p = tx_o;
      end
      repeat (period) @(negedge clk_i);
      if (tx_o !== 1'b1) ok = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_rxf;
    logic [7:0] exp_din;
    logic [4:0] exp_level;
    logic [2:0] exp_err;
  } rx_vec_t;

  rx_vec_t vecs [6];

  initial begin
    logic [7:0] b;
    logic       p;
    int         t;
    int         ts [3];
    logic [4:0] lvl;
    logic       txe_s;
    bit         ok;
    bit         seen_low;
    logic [7:0] txv [3];

    reset_n_i = 1'b0; rx_i = 1'b1; baud_div_i = 16'd9;
    cmdfifo_rd = 1'b0; cmdfifo_wr = 1'b0; cmdfifo_dout = '0; err_clr_i = 1'b0;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 5'd1, 3'b000};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 5'd1, 3'b000};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 5'd1, 3'b000};
    vecs[3] = '{8'h55, 1'b0, 1'b0, 8'h00, 5'd0, 3'b010};
    vecs[4] = '{8'h12, 1'b1, 1'b1, 8'h12, 5'd1, 3'b000};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 5'd1, 3'b000};

    repeat (3) @(negedge clk_i);
    check("rst_tx",    tx_o,        1);
    check("rst_rxf",   cmdfifo_rxf, 0);
    check("rst_txe",   cmdfifo_txe, 1);
    check("rst_rxlvl", rx_level_o,  0);
    check("rst_txlvl", tx_level_o,  0);
    check("rst_err",   err_o,       0);
    check("rst_din",   cmdfifo_din, 0);
    reset_n_i = 1'b1;
    repeat (3) @(negedge clk_i);

    // RX frame table
    for (int v = 0; v < 6; v++) begin
      send_rx(vecs[v].data, vecs[v].stop, 1'b0);
      check($sformatf("rx%0d_rxf", v),   cmdfifo_rxf, vecs[v].exp_rxf);
      check($sformatf("rx%0d_level", v), rx_level_o,  vecs[v].exp_level);
      check($sformatf("rx%0d_err", v),   err_o,       vecs[v].exp_err);
      if (vecs[v].exp_rxf) begin
        check($sformatf("rx%0d_din", v), cmdfifo_din, vecs[v].exp_din);
        pop();
        check($sformatf("rx%0d_rxf_after_rd", v), cmdfifo_rxf, 0);
        check($sformatf("rx%0d_lvl_after_rd", v), rx_level_o,  0);
      end
      clear_err();
      check($sformatf("rx%0d_err_clr", v), err_o, 0);
    end

    // Read while empty is ignored
    pop();
    check("empty_rd_level", rx_level_o, 0);

    // RX overflow: 17 bytes, no reads
    for (int i = 0; i < 17; i++) send_rx(8'h20 + 8'(i), 1'b1, 1'b0);
    check("ovf_level", rx_level_o, 16);
    check("ovf_err",   err_o,      3'b001);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovf_din%0d", i), cmdfifo_din, 8'h20 + 8'(i));
      pop();
    end
    check("ovf_drained_rxf", cmdfifo_rxf, 0);
    clear_err();
    check("ovf_err_clr", err_o, 0);

    // Back-to-back TX of three bytes
    txv[0] = 8'h00; txv[1] = 8'hFF; txv[2] = 8'h3C;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk_i) cmdfifo_wr = 1'b1; cmdfifo_dout = txv[i];
        end
        @(negedge clk_i) cmdfifo_wr = 1'b0;
      end
      begin
        for (int k = 0; k < 3; k++) begin
          tx_capture(BIT, 500, b, p, t, lvl, txe_s, ok);
          ts[k] = t;
          check($sformatf("tx3_ok%0d", k),   ok,    1);
          check($sformatf("tx3_byte%0d", k), b,     txv[k]);
          check($sformatf("tx3_lvl%0d", k),  lvl,   5'(2 - k));
          check($sformatf("tx3_txe%0d", k),  txe_s, 1);
        end
      end
    join
    check("tx3_gap01", ts[1] - ts[0], FB * BIT);
    check("tx3_gap12", ts[2] - ts[1], FB * BIT);
    repeat (2 * BIT) @(negedge clk_i);

    // Divisor below the floor is clamped to 7 (8-clock bits)
    baud_div_i = 16'd3;
    fork
      begin
        @(negedge clk_i) cmdfifo_wr = 1'b1; cmdfifo_dout = 8'hC3;
        @(negedge clk_i) cmdfifo_dout = 8'h5A;
        @(negedge clk_i) cmdfifo_wr = 1'b0;
      end
      begin
        tx_capture(8, 500, b, p, t, lvl, txe_s, ok);
        ts[0] = t;
        check("mindiv_byte0", b, 8'hC3);
        tx_capture(8, 500, b, p, t, lvl, txe_s, ok);
        ts[1] = t;
        check("mindiv_byte1", b, 8'h5A);
      end
    join
    check("mindiv_gap", ts[1] - ts[0], FB * 8);
    baud_div_i = 16'd9;
    repeat (2 * BIT) @(negedge clk_i);

    // TX FIFO full: 18 back-to-back writes, the last is ignored
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          @(negedge clk_i) cmdfifo_wr = 1'b1; cmdfifo_dout = 8'h40 + 8'(i);
        end
        @(negedge clk_i) cmdfifo_wr = 1'b0;
        check("txfull_level", tx_level_o,  16);
        check("txfull_txe",   cmdfifo_txe, 0);
      end
      begin
        for (int k = 0; k < 17; k++) begin
          tx_capture(BIT, 500, b, p, t, lvl, txe_s, ok);
          check($sformatf("txfull_byte%0d", k), b, 8'h40 + 8'(k));
        end
        tx_capture(BIT, 4 * BIT * FB, b, p, t, lvl, txe_s, ok);
        check("txfull_no_extra", ok, 0);
      end
    join

`ifdef SERIAL_FIFO_IFACE_PARITY_EN
    send_rx(8'h01, 1'b1, 1'b1);
    check("par_rx_rxf", cmdfifo_rxf, 0);
    check("par_rx_err", err_o, 3'b100);
    clear_err();
    check("par_err_clr", err_o, 0);
    @(negedge clk_i) cmdfifo_wr = 1'b1; cmdfifo_dout = 8'h03;
    fork
      begin
        @(negedge clk_i) cmdfifo_wr = 1'b0;
      end
      begin
        tx_capture(BIT, 500, b, p, t, lvl, txe_s, ok);
        check("par_tx_byte", b, 8'h03);
        check("par_tx_bit",  p, 0);
      end
    join
    repeat (2 * BIT) @(negedge clk_i);
`endif

    // Reset in the middle of a TX frame with a byte waiting in RX
    send_rx(8'h77, 1'b1, 1'b0);
    check("prerst_rxlvl", rx_level_o, 1);
    @(negedge clk_i) cmdfifo_wr = 1'b1; cmdfifo_dout = 8'h00;
    @(negedge clk_i) cmdfifo_dout = 8'h00;
    @(negedge clk_i) cmdfifo_wr = 1'b0;
    repeat (40) @(negedge clk_i);
    check("prerst_tx_low", tx_o, 0);
    #3 reset_n_i = 1'b0;
    #1;
    check("rst_async_tx",    tx_o,        1);
    check("rst_async_txlvl", tx_level_o,  0);
    check("rst_async_rxlvl", rx_level_o,  0);
    check("rst_async_rxf",   cmdfifo_rxf, 0);
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    seen_low = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1) seen_low = 1'b1;
    end
    check("postrst_tx_idle", seen_low, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
